alarm_sequencer: RTL

Sequences the alarm path of the alarm clock: detects the current-time/alarm-time match, then runs the ring, snooze and timeout sequence. Drives the buzzer gate, the beep pattern and status LEDs. Sits beside the alarm controller in the clk256 domain. Takes one_second/one_minute strobes from the time generator and stop/snooze key strobes from the keyboard interface.

---
 rtl/alarm_sequencer_if.sv | 29 ++
 rtl/alarm_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer signal bundle: time/key strobes in, alarm status out.
interface alarm_sequencer_if;
  logic        one_second;
  logic        one_minute;
  logic        alarm_on;
  logic [15:0] cur_time;
  logic [15:0] alarm_time;
  logic        stop_key;
  logic        snooze_key;
  logic        sound_alarm;
  logic        beep;
  logic        snoozing;
  logic        missed;
  logic [1:0]  snooze_left;

  // Driver side: supplies strobes, keys and times, observes status.
  modport master (
    output one_second, one_minute, alarm_on, cur_time, alarm_time,
           stop_key, snooze_key,
    input  sound_alarm, beep, snoozing, missed, snooze_left
  );

  // Sequencer side.
  modport slave (
    input  one_second, one_minute, alarm_on, cur_time, alarm_time,
           stop_key, snooze_key,
    output sound_alarm, beep, snoozing, missed, snooze_left
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: detects the rising edge of the time/alarm match and runs
// the ring / snooze / timeout sequence with fully registered outputs.
module alarm_sequencer #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic               clk256,
  input  logic               reset,
  alarm_sequencer_if.slave   bus
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECS);
  localparam logic [3:0] SNZ_LAST  = 4'(SNOOZE_MIN);
  localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_e;

  state_e      state_q;
  logic [7:0]  ring_cnt_q;
  logic [3:0]  snz_cnt_q;
  logic        match_q;
  logic        sound_q;
  logic        beep_q;
  logic        snoozing_q;
  logic        missed_q;
  logic [1:0]  snooze_left_q;

  logic        match_d;
  logic        trigger;
  logic [7:0]  ring_cnt_d;
  logic [3:0]  snz_cnt_d;
  logic        ring_timeout;
  logic        snz_done;
  logic        ring_stop;

  // Raw compare; only its rising edge starts a ring, so a match that is
  // already standing when the alarm is armed stays silent.
  assign match_d      = (bus.cur_time == bus.alarm_time);
  assign trigger      = match_d & ~match_q;
  assign ring_cnt_d   = ring_cnt_q + 8'd1;
  assign snz_cnt_d    = snz_cnt_q + 4'd1;
  // Terminal checks look at the incremented count so the counters never wrap.
  assign ring_timeout = bus.one_second & (ring_cnt_d == RING_LAST);
  assign snz_done     = bus.one_minute & (snz_cnt_d == SNZ_LAST);
  // With no snoozes left, the snooze key behaves as stop.
  assign ring_stop    = bus.stop_key | (bus.snooze_key & (snooze_left_q == 2'd0));

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk256 or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ring_cnt_q    <= 8'd0;
      snz_cnt_q     <= 4'd0;
      match_q       <= 1'b0;
      sound_q       <= 1'b0;
      beep_q        <= 1'b0;
      snoozing_q    <= 1'b0;
      missed_q      <= 1'b0;
      snooze_left_q <= SNZ_MAX;
    end else begin
      match_q <= match_d;
      if (!bus.alarm_on) begin
        state_q       <= IDLE;
        sound_q       <= 1'b0;
        beep_q        <= 1'b0;
        snoozing_q    <= 1'b0;
        missed_q      <= 1'b0;
        snooze_left_q <= SNZ_MAX;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (bus.stop_key) begin
              missed_q <= 1'b0;
            end else if (trigger) begin
              state_q    <= RINGING;
              ring_cnt_q <= 8'd0;
              sound_q    <= 1'b1;
              beep_q     <= 1'b1;
            end
          end
          RINGING: begin
            if (ring_stop) begin
              state_q       <= ARMED;
              sound_q       <= 1'b0;
              beep_q        <= 1'b0;
              missed_q      <= 1'b0;
              snooze_left_q <= SNZ_MAX;
            end else if (bus.snooze_key) begin
              state_q       <= SNOOZE;
              sound_q       <= 1'b0;
              beep_q        <= 1'b0;
              snoozing_q    <= 1'b1;
              snz_cnt_q     <= 4'd0;
              snooze_left_q <= snooze_left_q - 2'd1;
            end else if (ring_timeout) begin
              state_q       <= ARMED;
              sound_q       <= 1'b0;
              beep_q        <= 1'b0;
              missed_q      <= 1'b1;
              snooze_left_q <= SNZ_MAX;
            end else if (bus.one_second) begin
              ring_cnt_q <= ring_cnt_d;
              beep_q     <= ~beep_q;
            end
          end
          SNOOZE: begin
            if (bus.stop_key) begin
              state_q       <= ARMED;
              snoozing_q    <= 1'b0;
              snooze_left_q <= SNZ_MAX;
            end else if (snz_done) begin
              state_q    <= RINGING;
              snoozing_q <= 1'b0;
              sound_q    <= 1'b1;
              beep_q     <= 1'b1;
              ring_cnt_q <= 8'd0;
            end else if (bus.one_minute) begin
              snz_cnt_q <= snz_cnt_d;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sound_alarm = sound_q;
  assign bus.beep        = beep_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.missed      = missed_q;
  assign bus.snooze_left = snooze_left_q;

endmodule
